temporizador_alarme: RTL and testbench

TEMPORIZADOR_ALARME -- requirements
Module: temporizador_alarme

---
 rtl/alarme_pkg.sv | 16 +
 rtl/divisor_tick.sv | 39 +++
 rtl/temporizador_alarme.sv | 91 +++++++++
 tb/tb_temporizador_alarme.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/alarme_pkg.sv
// rtl/alarme_pkg.sv - shared state encoding and defaults for the alarm timer
//
// Purpose : state type and default interval width used by temporizador_alarme
//           and its helpers.
// Ports   : none (package)
package alarme_pkg;

    localparam int VALUE_W_DEFAULT = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_EXPIRED = 2'd2
    } alarme_state_t;

endpackage

// File: rtl/divisor_tick.sv
// rtl/divisor_tick.sv - free-running one-second tick divider with clear/enable
//
// Purpose : counts 0..CLK_DIV-1 while enabled and flags the last count so the
//           consumer can act on that same edge.
// Ports   : clock  - system clock
//           reset  - synchronous, active-high reset
//           clear  - restart the count from 0
//           enable - count only while high; count is held at 0 otherwise
//           tick   - high during the cycle whose closing edge ends a second
module divisor_tick #(
    parameter int CLK_DIV = 100000000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Holding the count at 0 whenever disabled means every interval starts a
    // full second away from its first tick.
    always_ff @(posedge clock) begin
        if (reset || clear || !enable) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/temporizador_alarme.sv
// rtl/temporizador_alarme.sv - loadable seconds countdown with expiry pulse
//
// Purpose : loads an interval on start_timer, counts it down once per second
//           and emits a single-cycle expired pulse when it runs out.
// Ports   : clock       - system clock
//           reset       - synchronous, active-high reset
//           value       - interval length in seconds, sampled on start only
//           start_timer - one-cycle load/restart request
//           expired     - one-cycle pulse when the interval has elapsed
//           busy        - high while counting
//           remaining   - seconds still to elapse
module temporizador_alarme
    import alarme_pkg::*;
#(
    parameter int CLK_DIV = 100000000,
    parameter int VALUE_W = VALUE_W_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [VALUE_W-1:0] value,
    input  logic               start_timer,
    output logic               expired,
    output logic               busy,
    output logic [VALUE_W-1:0] remaining
);

    alarme_state_t      state;
    alarme_state_t      state_next;
    logic [VALUE_W-1:0] rem_next;
    logic               tick;

    divisor_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_divisor_tick (
        .clock (clock),
        .reset (reset),
        .clear (start_timer),
        .enable(state == ST_COUNT),
        .tick  (tick)
    );

    // A start overrides whatever the current state would do, including a
    // tick landing on the same edge, so an abandoned interval never expires.
    always_comb begin
        state_next = state;
        rem_next   = remaining;
        if (start_timer) begin
            rem_next   = value;
            state_next = (value != '0) ? ST_COUNT : ST_EXPIRED;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_next = ST_IDLE;
                end
                ST_COUNT: begin
                    if (tick) begin
                        if (remaining > VALUE_W'(1)) begin
                            rem_next = remaining - 1'b1;
                        end else begin
                            rem_next   = '0;
                            state_next = ST_EXPIRED;
                        end
                    end
                end
                ST_EXPIRED: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up exactly
    // with the cycle the FSM spends in the matching state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            remaining <= '0;
            expired   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            remaining <= rem_next;
            expired   <= (state_next == ST_EXPIRED);
            busy      <= (state_next == ST_COUNT);
        end
    end

endmodule

// File: tb/tb_temporizador_alarme.sv
// tb/tb_temporizador_alarme.sv - randomized self-checking bench for temporizador_alarme
module tb_temporizador_alarme;

    localparam int D  = 4;
    localparam int VW = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [VW-1:0] value = '0;
    logic          start_timer = 1'b0;
    logic          expired;
    logic          busy;
    logic [VW-1:0] remaining;

    int total = 0;
    int bad   = 0;

    // Reference model: an interval is described by the edge that started it
    // and its length; outputs follow from elapsed edges with plain arithmetic.
    int edge_no  = 0;
    bit m_active = 1'b0;
    int m_t0     = 0;
    int m_v      = 0;
    int m_rem    = 0;

    temporizador_alarme #(
        .CLK_DIV(D),
        .VALUE_W(VW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .value      (value),
        .start_timer(start_timer),
        .expired    (expired),
        .busy       (busy),
        .remaining  (remaining)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", tag, edge_no, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit s, input int v);
        int e;
        int e_busy;
        int e_exp;
        int e_rem;
        @(negedge clock);
        reset       = r;
        start_timer = s;
        value       = VW'(v);
        @(posedge clock);
        edge_no++;
        if (r) begin
            m_active = 1'b0;
            m_rem    = 0;
        end else if (s) begin
            m_active = 1'b1;
            m_t0     = edge_no;
            m_v      = v;
        end
        e_busy = 0;
        e_exp  = 0;
        e_rem  = m_rem;
        if (m_active) begin
            e = edge_no - m_t0;
            if (e < m_v * D) begin
                e_busy = 1;
                e_rem  = m_v - e / D;
            end else if (e == m_v * D) begin
                e_exp  = 1;
                e_rem  = 0;
                m_rem  = 0;
            end else begin
                m_active = 1'b0;
                m_rem    = 0;
                e_rem    = 0;
            end
        end
        #1;
        check("busy", int'(busy), e_busy);
        check("expired", int'(expired), e_exp);
        check("remaining", int'(remaining), e_rem);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, int'(value));
    endtask

    initial begin
        // reset state
        step(1'b1, 1'b1, 9);
        step(1'b1, 1'b0, 0);

        // value=3: 12 busy cycles, expiry 12 edges after start
        step(1'b0, 1'b1, 3);
        idle(15);

        // value=0: immediate expiry, never busy
        step(1'b0, 1'b1, 0);
        idle(3);

        // restart during COUNT
        step(1'b0, 1'b1, 5);
        idle(8);
        step(1'b0, 1'b1, 2);
        idle(16);

        // reset mid-count aborts silently
        step(1'b0, 1'b1, 5);
        idle(6);
        step(1'b1, 1'b0, 5);
        idle(25);

        // value changed after start has no effect
        step(1'b0, 1'b1, 3);
        step(1'b0, 1'b0, 3);
        step(1'b0, 1'b0, 7);
        idle(12);

        // start during EXPIRED keeps the pulse and reloads
        step(1'b0, 1'b1, 1);
        idle(4);
        step(1'b0, 1'b1, 2);
        idle(10);

        // maximum value
        step(1'b0, 1'b1, 31);
        idle(130);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit r;
            bit s;
            int v;
            r = ($urandom_range(0, 299) == 0);
            s = ($urandom_range(0, 24) == 0);
            v = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31))
                                            : int'($urandom_range(0, 6));
            step(r, s, v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
